// File: rtl/stream_raster_gen_pkg.sv
// +--------------------------------------------------------------------+
// | stream_raster_gen_pkg                                              |
// | Shared FSM encoding and ceiling-log2 helper for raster stages.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package stream_raster_gen_pkg;

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    // Never returns less than 1 so a degenerate dimension still yields a legal vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_raster_gen_raster_counter.sv
// +--------------------------------------------------------------------+
// | raster_counter                                                     |
// | Enable-gated row/column wrap counter over a full frame raster.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module raster_counter
    import stream_raster_gen_pkg::*;
#(
    parameter int FRAME_HEIGHT = 4,
    parameter int FRAME_WIDTH  = 6,
    parameter int VCNT_WIDTH   = clog2(FRAME_HEIGHT),
    parameter int HCNT_WIDTH   = clog2(FRAME_WIDTH)
) (
    input  logic                  clock,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  advance,
    output logic [VCNT_WIDTH-1:0] vc,
    output logic [HCNT_WIDTH-1:0] hc
);

    logic [VCNT_WIDTH-1:0] base_v;
    logic [HCNT_WIDTH-1:0] base_h;
    logic [VCNT_WIDTH-1:0] next_v;
    logic [HCNT_WIDTH-1:0] next_h;

    // clear together with advance steps from (0,0), i.e. lands on the slot after origin.
    always_comb begin
        base_v = clear ? '0 : vc;
        base_h = clear ? '0 : hc;
        next_v = base_v;
        next_h = base_h;
        if (advance) begin
            if (base_h == HCNT_WIDTH'(FRAME_WIDTH - 1)) begin
                next_h = '0;
                if (base_v == VCNT_WIDTH'(FRAME_HEIGHT - 1)) begin
                    next_v = '0;
                end else begin
                    next_v = base_v + VCNT_WIDTH'(1);
                end
            end else begin
                next_h = base_h + HCNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            vc <= '0;
            hc <= '0;
        end else begin
            vc <= next_v;
            hc <= next_h;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_raster_gen.sv
// +--------------------------------------------------------------------+
// | stream_raster_gen                                                  |
// | Re-times a compact pixel stream onto the frame raster with blanks. |
// | Optional macro: STREAM_RASTER_GEN_SOF_CHECK_EN (sof_err + resync). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module stream_raster_gen
    import stream_raster_gen_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 3,
    parameter int IMAGE_WIDTH  = 4,
    parameter int FRAME_HEIGHT = 4,
    parameter int FRAME_WIDTH  = 6,
    parameter int VCNT_WIDTH   = clog2(FRAME_HEIGHT),
    parameter int HCNT_WIDTH   = clog2(FRAME_WIDTH)
) (
    input  logic                  clock,
    input  logic                  n_rst,
    input  logic [BIT_WIDTH-1:0]  in_pixel,
    input  logic                  in_sof,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef STREAM_RASTER_GEN_SOF_CHECK_EN
    output logic                  sof_err,
`endif
    output logic [BIT_WIDTH-1:0]  out_pixel,
    output logic [VCNT_WIDTH-1:0] out_vcnt,
    output logic [HCNT_WIDTH-1:0] out_hcnt,
    output logic                  out_enable
);

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [VCNT_WIDTH-1:0] vc;
    logic [HCNT_WIDTH-1:0] hc;
    logic                  image_slot;
    logic                  at_origin;
    logic                  fire;
    logic                  restart;
    logic                  err_set;
    logic [BIT_WIDTH-1:0]  emit_pix;
    logic [VCNT_WIDTH-1:0] emit_v;
    logic [HCNT_WIDTH-1:0] emit_h;

    assign image_slot = (int'(vc) < IMAGE_HEIGHT) && (int'(hc) < IMAGE_WIDTH);
    assign at_origin  = (vc == '0) && (hc == '0);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        fire       = 1'b0;
        restart    = 1'b0;
        err_set    = 1'b0;
        emit_pix   = '0;
        case (state)
            WAIT_SOF: begin
                in_ready = 1'b1;
                emit_pix = in_pixel;
                if (in_valid && in_sof) begin
                    fire       = 1'b1;
                    restart    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (image_slot) begin
                    in_ready = 1'b1;
                    fire     = in_valid;
                    emit_pix = in_pixel;
`ifdef STREAM_RASTER_GEN_SOF_CHECK_EN
                    restart  = in_valid && in_sof && !at_origin;
                    err_set  = in_valid && (in_sof != at_origin);
`endif
                end else begin
                    // Blanking slots are emitted unconditionally; input waits.
                    fire = 1'b1;
                end
            end
            default: state_next = WAIT_SOF;
        endcase
        emit_v = restart ? '0 : vc;
        emit_h = restart ? '0 : hc;
    end

    raster_counter #(
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .VCNT_WIDTH   (VCNT_WIDTH),
        .HCNT_WIDTH   (HCNT_WIDTH)
    ) u_raster_counter (
        .clock   (clock),
        .n_rst   (n_rst),
        .clear   (restart),
        .advance (fire),
        .vc      (vc),
        .hc      (hc)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state      <= WAIT_SOF;
            out_pixel  <= '0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
            out_enable <= 1'b0;
        end else begin
            state      <= state_next;
            out_enable <= fire;
            if (fire) begin
                out_pixel <= emit_pix;
                out_vcnt  <= emit_v;
                out_hcnt  <= emit_h;
            end
        end
    end

`ifdef STREAM_RASTER_GEN_SOF_CHECK_EN
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            sof_err <= 1'b0;
        end else if (err_set) begin
            sof_err <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_set ^ at_origin;
`endif

endmodule

`default_nettype wire
